// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM state type and default width for the serial subtractor
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// rtl/serial_subtractor_full_sub.sv - combinational one-bit full-subtractor cell
module full_sub (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic bor
);

    assign diff = a ^ b ^ b_in;
    assign bor  = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, LSB first, one full_sub cell and a registered borrow
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bor,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bor_q, bor_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic cell_diff;
    logic cell_bor;

    full_sub u_full_sub (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .b_in (borrow_q),
        .diff (cell_diff),
        .bor  (cell_bor)
    );

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        diff_d    = diff_q;
        bor_d     = bor_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    borrow_d  = b_in;
                    cnt_d     = '0;
                    diff_sh_d = '0;
                    a_msb_d   = a[WIDTH-1];
                    b_msb_d   = b[WIDTH-1];
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                borrow_d  = cell_bor;
                diff_sh_d = {cell_diff, diff_sh_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    // Publish results on the final bit so they are already valid in DONE.
                    diff_d  = diff_sh_d;
                    bor_d   = cell_bor;
                    ovf_d   = (a_msb_q != b_msb_q) && (diff_sh_d[WIDTH-1] != a_msb_q);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            diff_sh_q   <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            diff_q      <= '0;
            bor_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            diff_sh_q   <= diff_sh_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            diff_q      <= diff_d;
            bor_q       <= bor_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign diff      = diff_q;
    assign bor       = bor_q;
    assign ovf       = ovf_q;

endmodule
